pipe_ctrl: RTL and testbench

Central pipeline control unit for the quantr-i core. It merges stall requests from ID, EX and MEM into the 6-bit `stall` vector consumed by every pipeline register (`pc_reg`, `if_id`, `id_ex`, `ex_mem`, `mem_wb`). It also sequences multi-cycle EX operations through a start/done handshake with a timeout watchdog, and issues one-cycle pipeline flushes with a redirect PC. It is the producer side of the stall protocol that the inter-stage registers obey.

---
 rtl/pipe_ctrl_pkg.sv | 19 +
 rtl/pipe_ctrl_mc_watchdog.sv | 24 ++
 rtl/pipe_ctrl.sv | 121 ++++++++++++
 tb/tb_pipe_ctrl.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared defines for the quantr-i pipeline control: data width, stall encodings, FSM states.
package pipe_ctrl_pkg;

    localparam int MXLEN = 64;
    localparam logic [MXLEN-1:0] ZeroDWord = '0;

    // Each encoding freezes every stage up to and including the requester.
    localparam logic [5:0] STALL_NONE = 6'b000000;
    localparam logic [5:0] STALL_ID   = 6'b000111;
    localparam logic [5:0] STALL_EX   = 6'b001111;
    localparam logic [5:0] STALL_MEM  = 6'b011111;

    typedef enum logic [1:0] {
        PC_RUN     = 2'd0,
        PC_MC_WAIT = 2'd1,
        PC_FLUSH   = 2'd2
    } pc_state_e;

endpackage

// File: rtl/pipe_ctrl_mc_watchdog.sv
// Cycle counter for multi-cycle EX ops; flags expiry on the last permitted wait cycle.
module mc_watchdog #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int TO_W           = 7
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [TO_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clear)
            count <= '0;
        else if (enable)
            count <= count + 1'b1;
    end

    assign expired = enable && (count == TO_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller with multi-cycle EX sequencing and timeout watchdog.
// Define PIPE_CTRL_PERF_EN to add the stall-cycle and flush-count performance counters.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int TO_W           = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stallreq_id,
    input  logic             stallreq_mem,
    input  logic             ex_mc_start,
    input  logic             ex_mc_done,
    input  logic             flush_req,
    input  logic [MXLEN-1:0] flush_target,
    output logic [5:0]       stall,
    output logic             flush,
    output logic [MXLEN-1:0] new_pc,
    output logic             ex_mc_abort,
    output logic             mc_busy,
`ifdef PIPE_CTRL_PERF_EN
    output logic [31:0]      perf_stall_cycles,
    output logic [31:0]      perf_flush_count,
`endif
    output logic             timeout_err
);

    pc_state_e state;
    logic      ex_req;
    logic      wd_expired;

    // Counter sits at zero outside MC_WAIT, so it is already clear when an op starts.
    mc_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TO_W           (TO_W)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clear   (state != PC_MC_WAIT),
        .enable  (state == PC_MC_WAIT),
        .expired (wd_expired)
    );

    // A start in RUN stalls immediately unless a flush wins the same cycle.
    assign ex_req = (state == PC_RUN && ex_mc_start && !flush_req) ||
                    (state == PC_MC_WAIT && !ex_mc_done);

    always_comb begin
        stall = STALL_NONE;
        if (state != PC_FLUSH) begin
            if (stallreq_mem)
                stall = STALL_MEM;
            else if (ex_req)
                stall = STALL_EX;
            else if (stallreq_id)
                stall = STALL_ID;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= PC_RUN;
            flush       <= 1'b0;
            new_pc      <= ZeroDWord;
            ex_mc_abort <= 1'b0;
            mc_busy     <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            flush       <= 1'b0;
            ex_mc_abort <= 1'b0;
            mc_busy     <= 1'b0;
            case (state)
                PC_RUN: begin
                    if (flush_req) begin
                        new_pc <= flush_target;
                        flush  <= 1'b1;
                        state  <= PC_FLUSH;
                    end else if (ex_mc_start) begin
                        mc_busy <= 1'b1;
                        state   <= PC_MC_WAIT;
                    end
                end
                PC_MC_WAIT: begin
                    if (flush_req) begin
                        // A completing op is not aborted; the flush goes ahead either way.
                        new_pc      <= flush_target;
                        flush       <= 1'b1;
                        ex_mc_abort <= !ex_mc_done;
                        state       <= PC_FLUSH;
                    end else if (ex_mc_done) begin
                        state <= PC_RUN;
                    end else if (wd_expired) begin
                        ex_mc_abort <= 1'b1;
                        timeout_err <= 1'b1;
                        state       <= PC_RUN;
                    end else begin
                        mc_busy <= 1'b1;
                    end
                end
                PC_FLUSH: state <= PC_RUN;
                default:  state <= PC_RUN;
            endcase
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_cycles <= '0;
            perf_flush_count  <= '0;
        end else begin
            if (stall[0])
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
            if (state != PC_FLUSH && flush_req)
                perf_flush_count <= perf_flush_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl, built with an 8-cycle watchdog timeout.
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        stallreq_id, stallreq_mem, ex_mc_start, ex_mc_done, flush_req;
    logic [63:0] flush_target;
    logic [5:0]  stall;
    logic        flush, ex_mc_abort, mc_busy, timeout_err;
    logic [63:0] new_pc;

    int checks = 0;
    int errors = 0;

    pipe_ctrl #(.TIMEOUT_CYCLES(8), .TO_W(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .stallreq_id  (stallreq_id),
        .stallreq_mem (stallreq_mem),
        .ex_mc_start  (ex_mc_start),
        .ex_mc_done   (ex_mc_done),
        .flush_req    (flush_req),
        .flush_target (flush_target),
        .stall        (stall),
        .flush        (flush),
        .new_pc       (new_pc),
        .ex_mc_abort  (ex_mc_abort),
        .mc_busy      (mc_busy),
        .timeout_err  (timeout_err)
    );

    always #5 clk = ~clk;

    // Advance one cycle: inputs change 1ns after the edge, checks happen 2ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; stallreq_id = 0; stallreq_mem = 0; ex_mc_start = 0;
        ex_mc_done = 0; flush_req = 0; flush_target = '0;
        tick(); tick();
        rst = 1'b0;
        #2;
        checks++; if (stall !== 6'b000000) begin errors++; $display("FAIL reset_stall got=%b exp=000000", stall); end
        checks++; if ({flush, ex_mc_abort, mc_busy, timeout_err} !== 4'b0000) begin errors++; $display("FAIL reset_flags got=%b exp=0000", {flush, ex_mc_abort, mc_busy, timeout_err}); end
        checks++; if (new_pc !== 64'h0) begin errors++; $display("FAIL reset_new_pc got=%h exp=0", new_pc); end
        tick();
    endtask

    task automatic test_id_stall();
        stallreq_id = 1; #2;
        checks++; if (stall !== 6'b000111) begin errors++; $display("FAIL id_stall got=%b exp=000111", stall); end
        tick(); stallreq_id = 0; #2;
        checks++; if (stall !== 6'b000000) begin errors++; $display("FAIL id_release got=%b exp=000000", stall); end
        tick();
    endtask

    task automatic test_mem_priority();
        stallreq_id = 1; stallreq_mem = 1; #2;
        checks++; if (stall !== 6'b011111) begin errors++; $display("FAIL mem_id got=%b exp=011111", stall); end
        stallreq_id = 0; #1;
        checks++; if (stall !== 6'b011111) begin errors++; $display("FAIL mem_only got=%b exp=011111", stall); end
        tick(); stallreq_mem = 0; tick();
    endtask

    task automatic test_mc_done();
        ex_mc_start = 1; #2;
        checks++; if (stall !== 6'b001111 || mc_busy !== 1'b0) begin errors++; $display("FAIL mc_start stall=%b busy=%b exp=001111/0", stall, mc_busy); end
        tick(); ex_mc_start = 0;
        for (int c = 1; c <= 4; c++) begin
            #2;
            checks++; if (stall !== 6'b001111 || mc_busy !== 1'b1) begin errors++; $display("FAIL mc_wait c%0d stall=%b busy=%b exp=001111/1", c, stall, mc_busy); end
            tick();
        end
        ex_mc_done = 1; #2;
        checks++; if (stall !== 6'b000000 || mc_busy !== 1'b1) begin errors++; $display("FAIL mc_done stall=%b busy=%b exp=000000/1", stall, mc_busy); end
        tick(); ex_mc_done = 0; #2;
        checks++; if ({mc_busy, ex_mc_abort, timeout_err} !== 3'b000) begin errors++; $display("FAIL mc_after got=%b exp=000", {mc_busy, ex_mc_abort, timeout_err}); end
        tick();
    endtask

    task automatic test_timeout();
        int pulses = 0;
        ex_mc_start = 1; tick(); ex_mc_start = 0;
        for (int c = 1; c <= 8; c++) begin
            #2;
            if (ex_mc_abort === 1'b1) pulses++;
            checks++; if (mc_busy !== 1'b1) begin errors++; $display("FAIL to_busy c%0d got=%b exp=1", c, mc_busy); end
            tick();
        end
        #2;
        checks++; if ({ex_mc_abort, timeout_err, mc_busy} !== 3'b110) begin errors++; $display("FAIL to_expire got=%b exp=110", {ex_mc_abort, timeout_err, mc_busy}); end
        if (ex_mc_abort === 1'b1) pulses++;
        tick(); #2;
        if (ex_mc_abort === 1'b1) pulses++;
        checks++; if (pulses !== 1) begin errors++; $display("FAIL to_pulses got=%0d exp=1", pulses); end
        checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL to_sticky got=%b exp=1", timeout_err); end
        ex_mc_start = 1; tick(); ex_mc_start = 0; ex_mc_done = 1; #2;
        checks++; if (stall !== 6'b000000 || mc_busy !== 1'b1) begin errors++; $display("FAIL to_next_op stall=%b busy=%b exp=000000/1", stall, mc_busy); end
        tick(); ex_mc_done = 0; #2;
        checks++; if ({ex_mc_abort, timeout_err, mc_busy} !== 3'b010) begin errors++; $display("FAIL to_next_done got=%b exp=010", {ex_mc_abort, timeout_err, mc_busy}); end
        tick();
    endtask

    task automatic test_flush_mc();
        ex_mc_start = 1; tick(); ex_mc_start = 0; tick();
        flush_req = 1; flush_target = 64'h0000_0000_8000_0100; #2;
        checks++; if (stall !== 6'b001111 || ex_mc_abort !== 1'b0) begin errors++; $display("FAIL fl_req stall=%b abort=%b exp=001111/0", stall, ex_mc_abort); end
        tick(); flush_req = 0; flush_target = '0; stallreq_id = 1; ex_mc_start = 1; #2;
        checks++; if ({flush, ex_mc_abort, mc_busy} !== 3'b110) begin errors++; $display("FAIL fl_flags got=%b exp=110", {flush, ex_mc_abort, mc_busy}); end
        checks++; if (new_pc !== 64'h0000_0000_8000_0100) begin errors++; $display("FAIL fl_new_pc got=%h exp=80000100", new_pc); end
        checks++; if (stall !== 6'b000000) begin errors++; $display("FAIL fl_stall got=%b exp=000000", stall); end
        tick(); stallreq_id = 0; ex_mc_start = 0; #2;
        checks++; if ({flush, ex_mc_abort, mc_busy} !== 3'b000 || timeout_err !== 1'b1) begin errors++; $display("FAIL fl_back got=%b err=%b exp=000/1", {flush, ex_mc_abort, mc_busy}, timeout_err); end
        tick();
    endtask

    task automatic test_flush_run();
        flush_req = 1; ex_mc_start = 1; flush_target = 64'h0000_0000_0000_1234; #2;
        checks++; if (stall !== 6'b000000) begin errors++; $display("FAIL fr_stall got=%b exp=000000", stall); end
        tick(); flush_req = 0; ex_mc_start = 0; #2;
        checks++; if ({flush, mc_busy} !== 2'b10 || new_pc !== 64'h1234) begin errors++; $display("FAIL fr_flush got=%b pc=%h exp=10/1234", {flush, mc_busy}, new_pc); end
        tick(); #2;
        checks++; if (flush !== 1'b0) begin errors++; $display("FAIL fr_one_cycle got=%b exp=0", flush); end
        tick();
    endtask

    task automatic test_done_and_flush();
        ex_mc_start = 1; tick(); ex_mc_start = 0;
        ex_mc_done = 1; flush_req = 1; flush_target = 64'h0000_0000_0000_4000; tick();
        ex_mc_done = 0; flush_req = 0; #2;
        checks++; if ({flush, ex_mc_abort} !== 2'b10 || new_pc !== 64'h4000) begin errors++; $display("FAIL df got=%b pc=%h exp=10/4000", {flush, ex_mc_abort}, new_pc); end
        tick();
    endtask

    task automatic test_done_in_run();
        ex_mc_done = 1; #2;
        checks++; if (stall !== 6'b000000) begin errors++; $display("FAIL dr_stall got=%b exp=000000", stall); end
        tick(); ex_mc_done = 0; #2;
        checks++; if ({mc_busy, ex_mc_abort, flush} !== 3'b000) begin errors++; $display("FAIL dr_flags got=%b exp=000", {mc_busy, ex_mc_abort, flush}); end
        tick();
    endtask

    task automatic test_rst_mid();
        ex_mc_start = 1; tick(); ex_mc_start = 0; tick();
        rst = 1; tick(); rst = 0; #2;
        checks++; if ({flush, ex_mc_abort, mc_busy, timeout_err} !== 4'b0000 || stall !== 6'b000000 || new_pc !== 64'h0) begin errors++; $display("FAIL rm_clear flags=%b stall=%b pc=%h exp=0000/000000/0", {flush, ex_mc_abort, mc_busy, timeout_err}, stall, new_pc); end
        tick(); #2;
        checks++; if ({ex_mc_abort, mc_busy} !== 2'b00) begin errors++; $display("FAIL rm_no_abort got=%b exp=00", {ex_mc_abort, mc_busy}); end
        tick();
    endtask

    initial begin
        test_reset();
        test_id_stall();
        test_mem_priority();
        test_mc_done();
        test_timeout();
        test_flush_mc();
        test_flush_run();
        test_done_and_flush();
        test_done_in_run();
        test_rst_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
